// File: rtl/axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axi_rd_arbiter
// Description : Shares one AXI read channel between icache and dcache.
//               Serialises whole transactions (address issue plus full return
//               burst), routes beats to the granted cache and flags bursts
//               whose beat count disagrees with the requested length.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_rd_arbiter #(
    parameter int FIXED_PRIO = 0
) (
    input  logic        clk,
    input  logic        rstn,
    // icache side
    input  logic        i_r_req,
    input  logic [31:0] i_r_addr,
    input  logic [2:0]  i_r_size,
    input  logic [7:0]  i_r_length,
    input  logic        i_r_data_ready,
    output logic        i_r_rdy,
    output logic        i_ret_valid,
    output logic        i_ret_last,
    output logic [31:0] i_r_data,
    // dcache side
    input  logic        d_r_req,
    input  logic [31:0] d_r_addr,
    input  logic [2:0]  d_r_size,
    input  logic [7:0]  d_r_length,
    input  logic        d_r_data_ready,
    output logic        d_r_rdy,
    output logic        d_ret_valid,
    output logic        d_ret_last,
    output logic [31:0] d_r_data,
    // AXI read address channel
    output logic        ar_valid,
    output logic [31:0] ar_addr,
    output logic [2:0]  ar_size,
    output logic [7:0]  ar_len,
    input  logic        ar_ready,
    // AXI read data channel
    input  logic        r_valid,
    input  logic        r_last,
    input  logic [31:0] r_data,
    output logic        r_ready,
    // status
    output logic        len_err
);

    localparam logic c_FIXED = (FIXED_PRIO != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_gnt;        // 1 = dcache owns the channel
    logic        r_last_gnt;   // owner of the most recently completed burst
    logic [7:0]  r_beat_cnt;
    logic [31:0] r_addr;
    logic [2:0]  r_size;
    logic [7:0]  r_len;

    logic        w_any_req;
    logic        w_pick_d;
    logic        w_r_ready;
    logic        w_beat_hs;

    assign w_any_req = i_r_req | d_r_req;
    // dcache wins when alone, under fixed priority, or when icache was served last
    assign w_pick_d  = d_r_req & (~i_r_req | c_FIXED | ~r_last_gnt);
    assign w_r_ready = r_gnt ? d_r_data_ready : i_r_data_ready;
    assign w_beat_hs = (r_state == ST_R) & r_valid & w_r_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant decision, latched request fields and beat counter
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_gnt      <= 1'b0;
            r_last_gnt <= 1'b0;
            r_beat_cnt <= 8'd0;
            r_addr     <= 32'd0;
            r_size     <= 3'd0;
            r_len      <= 8'd0;
        end else begin
            if ((r_state == ST_IDLE) && w_any_req) begin
                r_gnt  <= w_pick_d;
                r_addr <= w_pick_d ? d_r_addr   : i_r_addr;
                r_size <= w_pick_d ? d_r_size   : i_r_size;
                r_len  <= w_pick_d ? d_r_length : i_r_length;
            end
            if ((r_state == ST_AR) && ar_ready) begin
                r_beat_cnt <= 8'd0;
            end
            if (w_beat_hs) begin
                r_beat_cnt <= r_beat_cnt + 8'd1;
                if (r_last) begin
                    r_last_gnt <= r_gnt;
                end
            end
        end
    end

    // Next state and outputs; every output is held low while rstn is asserted
    always_comb begin
        w_state_nxt = r_state;
        ar_valid    = 1'b0;
        ar_addr     = 32'd0;
        ar_size     = 3'd0;
        ar_len      = 8'd0;
        r_ready     = 1'b0;
        i_r_rdy     = 1'b0;
        i_ret_valid = 1'b0;
        i_ret_last  = 1'b0;
        i_r_data    = 32'd0;
        d_r_rdy     = 1'b0;
        d_ret_valid = 1'b0;
        d_ret_last  = 1'b0;
        d_r_data    = 32'd0;
        len_err     = 1'b0;
        if (rstn) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        w_state_nxt = ST_AR;
                    end
                end
                ST_AR: begin
                    ar_valid = 1'b1;
                    ar_addr  = r_addr;
                    ar_size  = r_size;
                    ar_len   = r_len;
                    if (ar_ready) begin
                        i_r_rdy     = ~r_gnt;
                        d_r_rdy     = r_gnt;
                        w_state_nxt = ST_R;
                    end
                end
                ST_R: begin
                    r_ready     = w_r_ready;
                    i_ret_valid = ~r_gnt & r_valid;
                    i_ret_last  = ~r_gnt & r_last;
                    d_ret_valid = r_gnt & r_valid;
                    d_ret_last  = r_gnt & r_last;
                    i_r_data    = r_data;
                    d_r_data    = r_data;
                    if (w_beat_hs && r_last) begin
                        w_state_nxt = ST_IDLE;
                        // count before this beat equals beats-minus-one for a correct burst
                        len_err     = (r_beat_cnt != r_len);
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_rd_arbiter
// Description : Scoreboard bench for axi_rd_arbiter. Expected address issues
//               and beats are queued when stimulus is launched and compared
//               as the DUT handshakes them on the AXI side.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_rd_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        i_r_req, i_r_data_ready, i_r_rdy, i_ret_valid, i_ret_last;
    logic [31:0] i_r_addr, i_r_data;
    logic [2:0]  i_r_size;
    logic [7:0]  i_r_length;
    logic        d_r_req, d_r_data_ready, d_r_rdy, d_ret_valid, d_ret_last;
    logic [31:0] d_r_addr, d_r_data;
    logic [2:0]  d_r_size;
    logic [7:0]  d_r_length;
    logic        ar_valid, ar_ready, r_valid, r_last, r_ready, len_err;
    logic [31:0] ar_addr, r_data;
    logic [2:0]  ar_size;
    logic [7:0]  ar_len;

    // second instance, fixed priority
    logic        p_i_r_req, p_i_r_data_ready, p_i_r_rdy, p_i_ret_valid, p_i_ret_last;
    logic [31:0] p_i_r_addr, p_i_r_data;
    logic [2:0]  p_i_r_size;
    logic [7:0]  p_i_r_length;
    logic        p_d_r_req, p_d_r_data_ready, p_d_r_rdy, p_d_ret_valid, p_d_ret_last;
    logic [31:0] p_d_r_addr, p_d_r_data;
    logic [2:0]  p_d_r_size;
    logic [7:0]  p_d_r_length;
    logic        p_ar_valid, p_ar_ready, p_r_valid, p_r_last, p_r_ready, p_len_err;
    logic [31:0] p_ar_addr, p_r_data;
    logic [2:0]  p_ar_size;
    logic [7:0]  p_ar_len;

    axi_rd_arbiter #(.FIXED_PRIO(0)) dut (
        .clk(clk), .rstn(rstn),
        .i_r_req(i_r_req), .i_r_addr(i_r_addr), .i_r_size(i_r_size), .i_r_length(i_r_length),
        .i_r_data_ready(i_r_data_ready), .i_r_rdy(i_r_rdy), .i_ret_valid(i_ret_valid),
        .i_ret_last(i_ret_last), .i_r_data(i_r_data),
        .d_r_req(d_r_req), .d_r_addr(d_r_addr), .d_r_size(d_r_size), .d_r_length(d_r_length),
        .d_r_data_ready(d_r_data_ready), .d_r_rdy(d_r_rdy), .d_ret_valid(d_ret_valid),
        .d_ret_last(d_ret_last), .d_r_data(d_r_data),
        .ar_valid(ar_valid), .ar_addr(ar_addr), .ar_size(ar_size), .ar_len(ar_len),
        .ar_ready(ar_ready), .r_valid(r_valid), .r_last(r_last), .r_data(r_data),
        .r_ready(r_ready), .len_err(len_err)
    );

    axi_rd_arbiter #(.FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rstn(rstn),
        .i_r_req(p_i_r_req), .i_r_addr(p_i_r_addr), .i_r_size(p_i_r_size), .i_r_length(p_i_r_length),
        .i_r_data_ready(p_i_r_data_ready), .i_r_rdy(p_i_r_rdy), .i_ret_valid(p_i_ret_valid),
        .i_ret_last(p_i_ret_last), .i_r_data(p_i_r_data),
        .d_r_req(p_d_r_req), .d_r_addr(p_d_r_addr), .d_r_size(p_d_r_size), .d_r_length(p_d_r_length),
        .d_r_data_ready(p_d_r_data_ready), .d_r_rdy(p_d_r_rdy), .d_ret_valid(p_d_ret_valid),
        .d_ret_last(p_d_ret_last), .d_r_data(p_d_r_data),
        .ar_valid(p_ar_valid), .ar_addr(p_ar_addr), .ar_size(p_ar_size), .ar_len(p_ar_len),
        .ar_ready(p_ar_ready), .r_valid(p_r_valid), .r_last(p_r_last), .r_data(p_r_data),
        .r_ready(p_r_ready), .len_err(p_len_err)
    );

    logic [115:0] all_outs;
    assign all_outs = {ar_valid, ar_addr, ar_size, ar_len, r_ready,
                       i_r_rdy, i_ret_valid, i_ret_last, i_r_data,
                       d_r_rdy, d_ret_valid, d_ret_last, d_r_data, len_err};

    typedef struct {
        logic        gnt;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [7:0]  len;
    } ar_exp_t;

    typedef struct {
        logic        gnt;
        logic [31:0] data;
        logic        last;
        logic        lerr;
    } beat_exp_t;

    ar_exp_t   ar_q[$];
    beat_exp_t bt_q[$];
    ar_exp_t   m_ea;
    beat_exp_t m_eb;

    int   errors = 0;
    int   checks = 0;
    logic in_r   = 1'b0;
    logic p_done = 1'b0;
    logic stop;
    logic seen_low;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Queue one transaction: its address issue and the beats expected to be accepted
    task automatic exp_txn(input logic g, input logic [31:0] addr, input logic [2:0] sz,
                           input logic [7:0] len, input int nb, input logic [31:0] base,
                           input int nexp);
        ar_q.push_back('{g, addr, sz, len});
        for (int b = 0; b < nexp; b++) begin
            bt_q.push_back('{g, base + 32'(b), (b == nb - 1),
                             ((b == nb - 1) && (nb - 1 != int'(len)))});
        end
    endtask

    // Cache-side requester: raise req, hold it until r_rdy is seen
    task automatic cache_rd(input logic is_d, input logic [31:0] addr, input logic [2:0] sz,
                            input logic [7:0] len);
        int t;
        if (is_d) begin
            d_r_req = 1'b1; d_r_addr = addr; d_r_size = sz; d_r_length = len;
        end else begin
            i_r_req = 1'b1; i_r_addr = addr; i_r_size = sz; i_r_length = len;
        end
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(is_d ? d_r_rdy : i_r_rdy) && t < 400);
        if (!(is_d ? d_r_rdy : i_r_rdy)) check_eq("r_rdy_timeout", 128'(0), 128'(1));
        @(posedge clk); #1;
        if (is_d) d_r_req = 1'b0;
        else      i_r_req = 1'b0;
    endtask

    // AXI slave: accept one address, then return nb beats (stop early at stop_at, beat left on bus)
    task automatic axi_txn(input int nb, input int ar_dly, input logic [31:0] base, input int stop_at);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!ar_valid && t < 300);
        if (!ar_valid) begin
            check_eq("ar_timeout", 128'(0), 128'(1));
            return;
        end
        repeat (ar_dly + 1) @(posedge clk);
        #1 ar_ready = 1'b1;
        @(posedge clk); #1;
        ar_ready = 1'b0;
        in_r     = 1'b1;
        for (int b = 0; b < nb; b++) begin
            r_valid = 1'b1;
            r_data  = base + 32'(b);
            r_last  = (b == nb - 1);
            if (b == stop_at) begin
                in_r = 1'b0;
                return;
            end
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!r_ready && t < 300);
            if (!r_ready) begin
                check_eq("beat_timeout", 128'(0), 128'(1));
                r_valid = 1'b0;
                in_r    = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        r_valid = 1'b0;
        r_last  = 1'b0;
        in_r    = 1'b0;
    endtask

    // Both caches request in the same cycle; first_d names the expected winner
    task automatic tie_pair(input logic first_d, input logic [31:0] dbase);
        exp_txn(first_d,  first_d ? 32'h1C00_0200 : 32'h0000_0200, 3'd4, 8'd3, 4, dbase, 4);
        exp_txn(!first_d, first_d ? 32'h0000_0200 : 32'h1C00_0200, 3'd4, 8'd3, 4,
                dbase + 32'h100, 4);
        fork
            cache_rd(1'b1, 32'h1C00_0200, 3'd4, 8'd3);
            cache_rd(1'b0, 32'h0000_0200, 3'd4, 8'd3);
            begin
                axi_txn(4, 0, dbase, -1);
                axi_txn(4, 0, dbase + 32'h100, -1);
            end
        join
    endtask

    task automatic phase_end(input string tag);
        check_eq(tag, 128'(ar_q.size() + bt_q.size()), 128'(0));
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Scoreboard: compare each address issue and each accepted beat with the queues
    always @(negedge clk) begin
        if (rstn && ar_valid && ar_ready) begin
            if (ar_q.size() == 0) begin
                check_eq("ar_unexpected", 128'(1), 128'(0));
            end else begin
                m_ea = ar_q.pop_front();
                check_eq("ar_addr", 128'(ar_addr), 128'(m_ea.addr));
                check_eq("ar_size", 128'(ar_size), 128'(m_ea.size));
                check_eq("ar_len", 128'(ar_len), 128'(m_ea.len));
                check_eq("r_rdy_gnt", 128'({i_r_rdy, d_r_rdy}), 128'(m_ea.gnt ? 2'b01 : 2'b10));
            end
        end
        if (rstn && r_valid && r_ready) begin
            if (bt_q.size() == 0) begin
                check_eq("beat_unexpected", 128'(1), 128'(0));
            end else begin
                m_eb = bt_q.pop_front();
                check_eq("ret_valid", 128'({i_ret_valid, d_ret_valid}),
                         128'(m_eb.gnt ? 2'b01 : 2'b10));
                check_eq("ret_last", 128'({i_ret_last, d_ret_last}),
                         128'({~m_eb.gnt & m_eb.last, m_eb.gnt & m_eb.last}));
                check_eq("ret_data", 128'(m_eb.gnt ? d_r_data : i_r_data), 128'(m_eb.data));
                check_eq("len_err", 128'(len_err), 128'(m_eb.lerr));
            end
        end
        if (rstn && len_err && !(r_valid && r_ready)) begin
            check_eq("len_err_spurious", 128'(len_err), 128'(0));
        end
    end

    // Fixed-priority instance: both caches request continuously, dcache must always win
    initial begin
        logic p_q[$];
        logic p_e;
        p_i_r_req = 1'b0; p_i_r_addr = 32'h0000_0400; p_i_r_size = 3'd4; p_i_r_length = 8'd0;
        p_d_r_req = 1'b0; p_d_r_addr = 32'h1C00_0400; p_d_r_size = 3'd4; p_d_r_length = 8'd0;
        p_i_r_data_ready = 1'b1; p_d_r_data_ready = 1'b1;
        p_ar_ready = 1'b0; p_r_valid = 1'b0; p_r_last = 1'b0; p_r_data = 32'h0;
        repeat (6) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) p_q.push_back(1'b1);
        p_i_r_req = 1'b1; p_d_r_req = 1'b1;
        p_ar_ready = 1'b1; p_r_valid = 1'b1; p_r_last = 1'b1; p_r_data = 32'h0BAD_F00D;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (p_ar_valid && p_ar_ready && p_q.size() > 0) begin
                p_e = p_q.pop_front();
                check_eq("fp_gnt", 128'({p_i_r_rdy, p_d_r_rdy}), 128'(p_e ? 2'b01 : 2'b10));
            end
        end
        check_eq("fp_grants", 128'(p_q.size()), 128'(0));
        p_i_r_req = 1'b0; p_d_r_req = 1'b0;
        p_ar_ready = 1'b0; p_r_valid = 1'b0; p_r_last = 1'b0;
        p_done = 1'b1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    // Main sequence
    initial begin
        rstn = 1'b0;
        i_r_req = 1'b0; i_r_addr = 32'h0; i_r_size = 3'd0; i_r_length = 8'd0; i_r_data_ready = 1'b1;
        d_r_req = 1'b0; d_r_addr = 32'h0; d_r_size = 3'd0; d_r_length = 8'd0; d_r_data_ready = 1'b1;
        ar_ready = 1'b1; r_valid = 1'b1; r_last = 1'b1; r_data = 32'hDEAD_BEEF;
        stop = 1'b0; seen_low = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("reset_outs", 128'(all_outs), 128'(0));
        @(posedge clk); #1 rstn = 1'b1;
        @(negedge clk);
        check_eq("post_reset_outs", 128'(all_outs), 128'(0));
        @(posedge clk); #1;
        ar_ready = 1'b0; r_valid = 1'b0; r_last = 1'b0; r_data = 32'h0;

        // ties after reset: dcache first, repeated tie keeps d,i order
        tie_pair(1'b1, 32'hA000_0000);
        phase_end("tie1_drain");
        tie_pair(1'b1, 32'hA100_0000);
        phase_end("tie2_drain");

        // single dcache line fill with address latency check
        exp_txn(1'b1, 32'h1C00_0040, 3'd4, 8'd15, 16, 32'h5500_0000, 16);
        fork
            cache_rd(1'b1, 32'h1C00_0040, 3'd4, 8'd15);
            axi_txn(16, 1, 32'h5500_0000, -1);
            begin
                @(negedge clk);
                check_eq("ar_lat_req_cycle", 128'(ar_valid), 128'(0));
                @(negedge clk);
                check_eq("ar_lat_next_cycle", 128'(ar_valid), 128'(1));
            end
        join
        phase_end("line_drain");

        // dcache served last, so the tie now goes to icache
        tie_pair(1'b0, 32'hA200_0000);
        phase_end("tie3_drain");

        // uncached single-beat read with d_r_data_ready toggling
        d_r_data_ready = 1'b0;
        stop = 1'b0;
        seen_low = 1'b0;
        exp_txn(1'b1, 32'h8000_0010, 3'd2, 8'd0, 1, 32'hCAFE_0000, 1);
        fork
            cache_rd(1'b1, 32'h8000_0010, 3'd2, 8'd0);
            begin
                axi_txn(1, 0, 32'hCAFE_0000, -1);
                stop = 1'b1;
            end
            begin : tog
                int k;
                k = 0;
                while (!stop) begin
                    @(posedge clk); #2;
                    if (in_r) begin
                        d_r_data_ready = k[0];
                        k++;
                    end
                end
            end
            begin
                while (!stop) begin
                    @(negedge clk);
                    if (in_r) begin
                        check_eq("r_ready_follow", 128'(r_ready), 128'(d_r_data_ready));
                        check_eq("icache_quiet", 128'(i_ret_valid), 128'(0));
                        if (r_valid && !r_ready) seen_low = 1'b1;
                    end
                end
            end
        join
        check_eq("rdy_low_seen", 128'(seen_low), 128'(1));
        d_r_data_ready = 1'b1;
        phase_end("uncached_drain");

        // early r_last: len 3 but burst ends on 2nd beat
        exp_txn(1'b0, 32'h0000_2000, 3'd4, 8'd3, 2, 32'h7700_0000, 2);
        fork
            cache_rd(1'b0, 32'h0000_2000, 3'd4, 8'd3);
            axi_txn(2, 0, 32'h7700_0000, -1);
        join
        r_valid = 1'b1; r_data = 32'h1234_5678;
        @(negedge clk);
        check_eq("idle_r_ready", 128'(r_ready), 128'(0));
        check_eq("idle_ret_valid", 128'({i_ret_valid, d_ret_valid}), 128'(0));
        @(posedge clk); #1;
        r_valid = 1'b0;
        phase_end("lenerr_drain");

        // reset on beat 5 of a 16-beat burst, then a fresh icache read
        exp_txn(1'b1, 32'h1C00_0100, 3'd4, 8'd15, 16, 32'h6600_0000, 4);
        fork
            cache_rd(1'b1, 32'h1C00_0100, 3'd4, 8'd15);
            axi_txn(16, 0, 32'h6600_0000, 4);
        join
        rstn = 1'b0;
        @(negedge clk);
        check_eq("mid_reset_outs", 128'(all_outs), 128'(0));
        @(posedge clk); #1 rstn = 1'b1;
        @(negedge clk);
        check_eq("after_abort_outs", 128'(all_outs), 128'(0));
        check_eq("after_abort_r_ready", 128'(r_ready), 128'(0));
        @(posedge clk); #1;
        r_valid = 1'b0; r_last = 1'b0;
        exp_txn(1'b0, 32'h0000_3000, 3'd4, 8'd1, 2, 32'h8800_0000, 2);
        fork
            cache_rd(1'b0, 32'h0000_3000, 3'd4, 8'd1);
            axi_txn(2, 0, 32'h8800_0000, -1);
        join
        phase_end("final_drain");

        wait (p_done);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Shares the single AXI read channel between the instruction cache and the data cache.
- Each cache presents its native read interface: r_req, r_addr, r_size, r_length, r_rdy, ret_valid, ret_last and read data.
- The arbiter serialises transactions: one address issue plus its full return burst at a time, with the grant locked until the last beat.
- It sits between the two cache controllers and the AXI bridge. It also checks burst length and flags protocol mismatches.

Parameters:
- FIXED_PRIO, 0: 0 = round-robin between caches; 1 = dcache always wins ties.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- i_r_req  in  1  icache read request
- i_r_addr  in  32  icache read address
- i_r_size  in  3  icache size (0/1/2 byte/half/word, 4 line)
- i_r_length  in  8  icache beats minus 1
- i_r_data_ready  in  1  icache can accept a beat
- i_r_rdy  out  1  icache address accepted (1-cycle pulse)
- i_ret_valid  out  1  beat valid to icache
- i_ret_last  out  1  last beat to icache
- i_r_data  out  32  beat data to icache
- d_r_req, d_r_addr, d_r_size, d_r_length, d_r_data_ready  in  1/32/3/8/1  dcache equivalents
- d_r_rdy, d_ret_valid, d_ret_last  out  1 each  dcache equivalents
- d_r_data  out  32  dcache equivalent
- ar_valid  out  1  AXI address valid
- ar_addr  out  32  AXI address
- ar_size  out  3  AXI size
- ar_len  out  8  AXI length
- ar_ready  in  1  AXI address ready
- r_valid  in  1  AXI beat valid
- r_last  in  1  AXI last beat
- r_data  in  32  AXI beat data
- r_ready  out  1  AXI beat ready
- len_err  out  1  1-cycle pulse on burst length mismatch

Behaviour:
- Reset (rstn=0 sampled at posedge) puts the block in IDLE and clears gnt, beat_cnt and latched request regs.
- last_gnt resets to icache, so the first tie goes to dcache.
- During reset all outputs are 0. Reset mid-burst aborts the transaction; remaining beats from AXI are not routed (r_ready=0, ret_valid=0).
- States are IDLE, AR and R.
- IDLE:
  - If any req is high, choose gnt and latch that requester's addr/size/length. Go to AR next cycle.
  - Tie rule: FIXED_PRIO=1 → dcache wins. FIXED_PRIO=0 → the requester not equal to last_gnt wins.
  - A single requester always wins.
  - Latency: req high in cycle N gives ar_valid=1 in cycle N+1.
- AR:
  - ar_valid=1, with ar_addr/ar_size/ar_len taken from the latched regs. They stay stable until ar_ready.
  - On ar_valid&ar_ready, the granted cache's r_rdy is 1 in that same cycle (combinational). beat_cnt clears to 0 and the state goes to R.
  - The granted requester must hold req until it sees r_rdy. Deasserting req earlier does not cancel the issue.
- R:
  - r_ready equals the granted cache's r_data_ready.
  - Granted cache: ret_valid=r_valid and ret_last=r_last.
  - Ungranted cache: ret_valid=0 and ret_last=0.
  - r_data is broadcast to both i_r_data and d_r_data.
  - Each r_valid&r_ready increments beat_cnt, an 8-bit counter that wraps.
  - On the handshake where r_last=1: go to IDLE and set last_gnt=gnt. If beat_cnt≠latched length, pulse len_err in that cycle.
  - Beats with r_ready=0 are held by AXI and are neither counted nor lost.
- Ungranted requests are ignored outside IDLE and are serviced on the next IDLE arbitration.
- There is a mandatory 1-cycle IDLE bubble between transactions.
- r_valid seen in IDLE or AR is not acknowledged: r_ready=0.
- Both *_r_rdy outputs are 0 in all states other than AR.

Test Plan:
- Only d_r_req=1, addr=0x1C000040, size=4, len=15; ar_ready at cycle+3:
  - ar_valid rises one cycle after req; ar_addr=0x1C000040, ar_len=15.
  - d_r_rdy pulses with ar_ready.
  - 16 beats routed to dcache only, d_ret_last on the 16th; len_err=0.
- i_r_req and d_r_req rise together, FIXED_PRIO=0, after reset:
  - dcache is granted first, icache next after a 1-cycle IDLE bubble.
  - Repeating the tie gives the alternating order d,i.
- Same tie with FIXED_PRIO=1: dcache wins every time.
- Uncached dcache read, size=2, len=0, d_r_data_ready toggles 0/1 during R:
  - r_ready follows it and the single beat is delivered once r_ready=1.
  - icache sees i_ret_valid=0 throughout.
- Granted burst len=3 but AXI asserts r_last on the 2nd beat: len_err pulses 1 cycle and the state returns to IDLE.
- rstn=0 for 1 cycle mid-burst (beat 5 of 16):
  - Next cycle is IDLE with all outputs 0 and r_ready=0.
  - A new i_r_req is then granted normally.
